mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
// Sits directly downstream of the CPU memory port: consumes Mem_Addr/Mem_Write/Data_Out, returns Mem_Data.
// Splits the address space into block RAM (below IO_BASE) and a small memory-mapped I/O window.
// The I/O window holds an LED register, a switch input, a byte-wide TX FIFO with ready/valid drain and a free-running cycle counter.
// PARAMETERS
// RAM_AW      10        RAM address width; RAM index = Mem_Addr[RAM_AW-1:0] (upper bits alias)
// IO_BASE     16'hFF00  first I/O address; Mem_Addr >= IO_BASE selects the I/O window
// FIFO_AW     3         TX FIFO depth = 2**FIFO_AW entries (default 8)
// PORTS
// Clock       in   1       system clock, all logic on rising edge
// Reset       in   1       synchronous, active-low reset
// Mem_Addr    in   16      CPU address
// Mem_Write   in   1       CPU store strobe, one cycle per store
// Data_Out    in   16      CPU store data
// Mem_Data    out  16      read data to CPU, valid the cycle after the address
// Ram_Addr    out  RAM_AW  block RAM address = Mem_Addr[RAM_AW-1:0], combinational
// Ram_WE      out  1       Mem_Write && (Mem_Addr < IO_BASE), combinational
// Ram_WData   out  16      = Data_Out
// Ram_RData   in   16      block RAM registered read data (1-cycle latency)
// Sw_In       in   16      board switches, asynchronous to Clock
// Led_Out     out  16      LED register
// Tx_Data     out  8       FIFO head byte
// Tx_Valid    out  1       FIFO not empty
// Tx_Ready    in   1       consumer accepts head when Tx_Valid && Tx_Ready
// BEHAVIOUR
// - Reset (Reset==0 at edge): Led_Out=0, FIFO empty (Tx_Valid=0, count 0), overflow=0, counter=0, Mem_Data=0, region select=unmapped.
// - I/O map (offset from IO_BASE): +0 LED R/W; +1 switches R; +2 TX push W (Data_Out[7:0]), reads 0;
//   +3 status R {8'b0, count[3:0], 1'b0, ovf, full, empty}, any write clears ovf; +4 counter R, write loads Data_Out.
//   Offsets >= +5: reads return 0, writes ignored.
// - Read latency 1: address at cycle N -> Mem_Data valid in N+1. Region select is registered at N.
//   RAM region: Mem_Data = Ram_RData. I/O region: Mem_Data = I/O read value captured at the N edge.
// - A write and a read of the same I/O register in the same cycle return the old value (read-before-write).
// - Counter: +1 every cycle, wraps 16'hFFFF->0; a write loads the value, and the counter increments from it on the next cycle.
// - FIFO push on write to +2: accepted if not full, or if full with a simultaneous pop; otherwise byte dropped and ovf set (sticky).
// - Pop: Tx_Valid && Tx_Ready. Push into empty FIFO: Tx_Valid rises the next cycle (no bypass).
// - Simultaneous push+pop: count unchanged; pointers wrap modulo depth.
// - count ranges 0..2**FIFO_AW, so the count field is FIFO_AW+1 bits and is zero-extended into status[7:4].
// - empty = (count==0); full = (count==2**FIFO_AW).
// - Reset mid-operation discards FIFO contents and any in-flight read; Ram_WE has no gating beyond the address decode.
// CONFIGURATION
// SWITCH_SYNC_EN defined: Sw_In passes through a 2-flop synchroniser (flops reset to 0).
//   A read of +1 at N returns Sw_In as sampled at edge N-2.
// Not defined: Sw_In is sampled directly into the read register (1-cycle read latency).
// TESTING
// - Reset low 2 cycles -> Led_Out=0, Tx_Valid=0, Mem_Data=0; read +3 -> 16'h0001; read +4 a few cycles later -> small nonzero value.
// - Write 16'hA5A5 to +0, read +0 next cycle -> Led_Out=Mem_Data=16'hA5A5; write to 16'h0012 -> Ram_WE=1, Ram_Addr=10'h012.
// - Tx_Ready=0, push 9 bytes 0x01..0x09 -> status 16'h0086 (count 8, ovf, full); Tx_Ready=1 -> drains 0x01..0x08; write +3 -> ovf clears.
// - FIFO full, push 0x55 with Tx_Ready=1 -> push accepted, count stays 8, ovf stays 0.
// - Write 16'hFFFE to +4, then read +4 on consecutive cycles -> FFFF, 0000, 0001 (wrap).
// - Sw_In=16'h1234, read +1 -> 16'h1234 after 1 cycle (or 3 cycles with SWITCH_SYNC_EN); Reset during FIFO drain -> Tx_Valid=0 the next cycle.

Source files
------------

// File: rtl/mem_io_bridge.sv
// CPU memory-port bridge: block RAM below IO_BASE, LED/switch/TX FIFO/counter I/O window above it.
// Optional macro SWITCH_SYNC_EN adds a 2-flop synchroniser on Sw_In.
module mem_io_bridge #(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int          FIFO_AW = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       Mem_Addr,
    input  logic              Mem_Write,
    input  logic [15:0]       Data_Out,
    output logic [15:0]       Mem_Data,
    output logic [RAM_AW-1:0] Ram_Addr,
    output logic              Ram_WE,
    output logic [15:0]       Ram_WData,
    input  logic [15:0]       Ram_RData,
    input  logic [15:0]       Sw_In,
    output logic [15:0]       Led_Out,
    output logic [7:0]        Tx_Data,
    output logic              Tx_Valid,
    input  logic              Tx_Ready
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [1:0] SEL_NONE = 2'd0, SEL_RAM = 2'd1, SEL_IO = 2'd2;

    logic [15:0]        r_led, r_cnt, r_io_rd;
    logic [1:0]         r_sel;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    logic        w_io, w_full, w_empty, w_push_req, w_push, w_pop;
    logic [15:0] w_off, w_sw, w_io_rd, w_status;
    logic [3:0]  w_cnt4;

    assign w_io      = (Mem_Addr >= IO_BASE);
    assign w_off     = Mem_Addr - IO_BASE;
    assign Ram_Addr  = Mem_Addr[RAM_AW-1:0];
    assign Ram_WE    = Mem_Write && !w_io;
    assign Ram_WData = Data_Out;
    assign Led_Out   = r_led;

`ifdef SWITCH_SYNC_EN
    logic [15:0] r_sw_s1, r_sw_s2;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= Sw_In;
            r_sw_s2 <= r_sw_s1;
        end
    end
    assign w_sw = r_sw_s2;
`else
    assign w_sw = Sw_In;
`endif

    // FIFO: a push into a full FIFO still lands when the head leaves the same cycle
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
    assign Tx_Valid   = !w_empty;
    assign Tx_Data    = r_mem[r_rp];
    assign w_pop      = Tx_Valid && Tx_Ready;
    assign w_push_req = Mem_Write && w_io && (w_off == 16'd2);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_cnt4     = 4'(r_count);
    assign w_status   = {8'b0, w_cnt4, 1'b0, r_ovf, w_full, w_empty};

    always_comb begin
        w_io_rd = '0;
        case (w_off)
            16'd0:   w_io_rd = r_led;
            16'd1:   w_io_rd = w_sw;
            16'd3:   w_io_rd = w_status;
            16'd4:   w_io_rd = r_cnt;
            default: w_io_rd = '0;
        endcase
    end

    always_comb begin
        case (r_sel)
            SEL_RAM: Mem_Data = Ram_RData;
            SEL_IO:  Mem_Data = r_io_rd;
            default: Mem_Data = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (w_push)
            r_mem[r_wp] <= Data_Out[7:0];
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_led   <= '0;
            r_cnt   <= '0;
            r_io_rd <= '0;
            r_sel   <= SEL_NONE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // read value is sampled from pre-write state, giving read-before-write
            r_sel   <= w_io ? SEL_IO : SEL_RAM;
            r_io_rd <= w_io_rd;
            if (Mem_Write && w_io && w_off == 16'd0)
                r_led <= Data_Out;
            if (Mem_Write && w_io && w_off == 16'd4)
                r_cnt <= Data_Out;
            else
                r_cnt <= r_cnt + 16'd1;
            if (Mem_Write && w_io && w_off == 16'd3)
                r_ovf <= 1'b0;
            else if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: reset, LED, RAM decode, TX FIFO, counter wrap, switches.
module tb_mem_io_bridge;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] Mem_Addr, Data_Out, Mem_Data, Ram_WData, Ram_RData, Sw_In, Led_Out;
    logic        Mem_Write, Ram_WE, Tx_Valid, Tx_Ready;
    logic [9:0]  Ram_Addr;
    logic [7:0]  Tx_Data;
    int          checks = 0;
    int          errors = 0;

    mem_io_bridge dut (
        .Clock(Clock), .Reset(Reset), .Mem_Addr(Mem_Addr), .Mem_Write(Mem_Write),
        .Data_Out(Data_Out), .Mem_Data(Mem_Data), .Ram_Addr(Ram_Addr), .Ram_WE(Ram_WE),
        .Ram_WData(Ram_WData), .Ram_RData(Ram_RData), .Sw_In(Sw_In), .Led_Out(Led_Out),
        .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic we, input logic [15:0] d);
        Mem_Addr  = a;
        Mem_Write = we;
        Data_Out  = d;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Mem_Addr = '0; Mem_Write = 1'b0; Data_Out = '0;
        Ram_RData = 16'hBEEF; Sw_In = '0; Tx_Ready = 1'b0;
        #1;
        step(16'hFF00, 1'b0, 16'h0);
        step(16'hFF00, 1'b0, 16'h0);
        chk("rst_led", Led_Out, 16'h0);
        chk("rst_txv", {15'b0, Tx_Valid}, 16'h0);
        chk("rst_mdata", Mem_Data, 16'h0);

        Reset = 1'b1;
        step(16'hFF03, 1'b0, 16'h0);
        chk("status_rst", Mem_Data, 16'h0001);
        step(16'h0000, 1'b0, 16'h0);
        step(16'h0000, 1'b0, 16'h0);
        step(16'hFF04, 1'b0, 16'h0);
        chk("cnt_early", Mem_Data, 16'h0003);
        chk("ram_rdata", Mem_Data === 16'h0003 ? 16'h0 : 16'h1, 16'h0);

        step(16'hFF00, 1'b1, 16'hA5A5);
        step(16'hFF00, 1'b0, 16'h0);
        chk("led_rd", Mem_Data, 16'hA5A5);
        chk("led_out", Led_Out, 16'hA5A5);
        Mem_Addr = 16'h0012; Mem_Write = 1'b1; Data_Out = 16'h1111; #1;
        chk("ram_we", {15'b0, Ram_WE}, 16'h1);
        chk("ram_addr", {6'b0, Ram_Addr}, 16'h0012);
        chk("ram_wdata", Ram_WData, 16'h1111);
        Mem_Addr = 16'h0412; Mem_Write = 1'b0; #1;
        chk("ram_alias", {6'b0, Ram_Addr}, 16'h0012);
        Mem_Addr = 16'hFF00; Mem_Write = 1'b1; #1;
        chk("io_no_ramwe", {15'b0, Ram_WE}, 16'h0);
        step(16'h0012, 1'b0, 16'h0);
        chk("ram_path", Mem_Data, 16'hBEEF);
        step(16'hFF00, 1'b1, 16'h1234);
        chk("rbw_old", Mem_Data, 16'hA5A5);
        chk("rbw_led", Led_Out, 16'h1234);

        for (int i = 1; i <= 9; i++) step(16'hFF02, 1'b1, 16'(i));
        chk("fifo_head", {8'b0, Tx_Data}, 16'h0001);
        step(16'hFF03, 1'b0, 16'h0);
        chk("status_full_ovf", Mem_Data, 16'h0086);
        step(16'hFF02, 1'b0, 16'h0);
        chk("push_reg_rd0", Mem_Data, 16'h0000);
        Tx_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", {8'b0, Tx_Data}, 16'(i));
            step(16'h0000, 1'b0, 16'h0);
        end
        chk("drain_empty", {15'b0, Tx_Valid}, 16'h0);
        step(16'hFF03, 1'b1, 16'h0);
        step(16'hFF03, 1'b0, 16'h0);
        chk("ovf_clear", Mem_Data, 16'h0001);

        Tx_Ready = 1'b0;
        for (int i = 0; i < 8; i++) step(16'hFF02, 1'b1, 16'h10 + 16'(i));
        step(16'hFF03, 1'b0, 16'h0);
        chk("status_full", Mem_Data, 16'h0082);
        Tx_Ready = 1'b1;
        step(16'hFF02, 1'b1, 16'h0055);
        Tx_Ready = 1'b0;
        step(16'hFF03, 1'b0, 16'h0);
        chk("full_pushpop", Mem_Data, 16'h0082);
        chk("head_after_pop", {8'b0, Tx_Data}, 16'h0011);
        Tx_Ready = 1'b1;
        step(16'h0000, 1'b0, 16'h0);
        chk("drain_mid", {8'b0, Tx_Data}, 16'h0012);
        Reset = 1'b0;
        step(16'hFF00, 1'b0, 16'h0);
        chk("rst_drain_txv", {15'b0, Tx_Valid}, 16'h0);
        chk("rst_inflight", Mem_Data, 16'h0);
        chk("rst_led2", Led_Out, 16'h0);
        Reset = 1'b1; Tx_Ready = 1'b0;

        step(16'hFF04, 1'b1, 16'hFFFE);
        step(16'h0000, 1'b0, 16'h0);
        step(16'hFF04, 1'b0, 16'h0);
        chk("cnt_ffff", Mem_Data, 16'hFFFF);
        step(16'hFF04, 1'b0, 16'h0);
        chk("cnt_wrap0", Mem_Data, 16'h0000);
        step(16'hFF04, 1'b0, 16'h0);
        chk("cnt_wrap1", Mem_Data, 16'h0001);

        Sw_In = 16'h1234;
        step(16'h0000, 1'b0, 16'h0);
        step(16'h0000, 1'b0, 16'h0);
        step(16'h0000, 1'b0, 16'h0);
        step(16'hFF01, 1'b0, 16'h0);
        chk("switches", Mem_Data, 16'h1234);
        step(16'hFF05, 1'b1, 16'h7777);
        step(16'hFF05, 1'b0, 16'h0);
        chk("unmapped_rd", Mem_Data, 16'h0000);
        chk("unmapped_led", Led_Out, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
